// File: rtl/connect_n_core.sv
// Connect-N game engine: cursor control, gravity drop, win/draw detection,
// per-turn timer. One win direction is evaluated per CHECK cycle.
module connect_n_core #(
    parameter int ROWS      = 6,
    parameter int COLS      = 7,
    parameter int WIN_LEN   = 4,
    parameter int TICK_DIV  = 25000000,
    parameter int TURN_SECS = 10
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             move_left,
    input  logic                             move_right,
    input  logic                             move_made,
    input  logic                             new_game,
    output logic [ROWS*COLS*2-1:0]           board,
    output logic [$clog2(COLS)-1:0]          cursor_col,
    output logic                             player_turn,
    output logic [2:0]                       state,
    output logic [1:0]                       winner,
    output logic [$clog2(TURN_SECS+1)-1:0]   seconds_left,
    output logic [$clog2(ROWS*COLS+1)-1:0]   move_count,
    output logic                             col_full,
    output logic                             timeout
);

    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(TURN_SECS+1);
    localparam int MW = $clog2(ROWS*COLS+1);
    localparam int TW = $clog2(TICK_DIV+1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [2:0] {
        S_PLAY   = 3'd0,
        S_DROP   = 3'd1,
        S_CHECK  = 3'd2,
        S_SWITCH = 3'd3,
        S_WIN    = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    logic [ROWS*COLS*2-1:0] r_board;
    logic [CW-1:0]          r_cursor;
    logic                   r_turn;
    state_t                 r_state;
    logic [1:0]             r_winner;
    logic [SW-1:0]          r_secs;
    logic [MW-1:0]          r_moves;
    logic                   r_col_full;
    logic                   r_timeout;
    logic [TW-1:0]          r_tick;
    logic [RW-1:0]          r_row;
    logic [1:0]             r_dir;

    logic [RW-1:0] w_row;
    logic          w_full;
    logic [1:0]    w_me;
    logic          w_tick;
    logic          w_win;
    logic          w_fwd;
    logic          w_bwd;
    int            w_rr;
    int            w_cc;
    int            w_dr;
    int            w_dc;
    int            w_cnt;

    // Off-board coordinates read as empty, which never matches a player code.
    function automatic logic [1:0] cell_at(
        input logic [ROWS*COLS*2-1:0] b,
        input int r,
        input int c
    );
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 2'b00;
        return b[(r*COLS+c)*2 +: 2];
    endfunction

    assign w_rr   = int'(r_row);
    assign w_cc   = int'(r_cursor);
    assign w_me   = r_turn ? 2'b10 : 2'b01;
    assign w_tick = (r_tick == TW'(TICK_DIV-1));
    assign w_win  = (w_cnt >= WIN_LEN);

    always_comb begin
        w_row  = '0;
        w_full = (cell_at(r_board, 0, w_cc) != 2'b00);
        for (int r = 0; r < ROWS; r++) begin
            if (cell_at(r_board, r, w_cc) == 2'b00) w_row = RW'(r);
        end
    end

    always_comb begin
        w_dr = 0;
        w_dc = 1;
        unique case (r_dir)
            2'd0:    begin w_dr = 0;  w_dc = 1; end
            2'd1:    begin w_dr = 1;  w_dc = 0; end
            2'd2:    begin w_dr = 1;  w_dc = 1; end
            default: begin w_dr = -1; w_dc = 1; end
        endcase
        w_cnt = 1;
        w_fwd = 1'b1;
        w_bwd = 1'b1;
        for (int k = 1; k < WIN_LEN; k++) begin
            if (w_fwd && cell_at(r_board, w_rr + k*w_dr, w_cc + k*w_dc) == w_me)
                w_cnt = w_cnt + 1;
            else
                w_fwd = 1'b0;
            if (w_bwd && cell_at(r_board, w_rr - k*w_dr, w_cc - k*w_dc) == w_me)
                w_cnt = w_cnt + 1;
            else
                w_bwd = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board    <= '0;
            r_cursor   <= '0;
            r_turn     <= 1'b0;
            r_state    <= S_PLAY;
            r_winner   <= 2'b00;
            r_secs     <= SW'(TURN_SECS);
            r_moves    <= '0;
            r_col_full <= 1'b0;
            r_timeout  <= 1'b0;
            r_tick     <= '0;
            r_row      <= '0;
            r_dir      <= '0;
        end else begin
            r_col_full <= 1'b0;
            r_timeout  <= 1'b0;
            if (new_game) begin
                r_board  <= '0;
                r_cursor <= '0;
                r_turn   <= 1'b0;
                r_state  <= S_PLAY;
                r_winner <= 2'b00;
                r_secs   <= SW'(TURN_SECS);
                r_moves  <= '0;
                r_tick   <= '0;
                r_row    <= '0;
                r_dir    <= '0;
            end else begin
                unique case (r_state)
                    S_PLAY: begin
                        r_tick <= w_tick ? '0 : r_tick + TW'(1);
                        if (move_made) begin
                            if (w_full) begin
                                r_col_full <= 1'b1;
                            end else begin
                                r_row   <= w_row;
                                r_state <= S_DROP;
                            end
                        end else begin
                            if (move_left && !move_right)
                                r_cursor <= (r_cursor == '0) ? CW'(COLS-1) : r_cursor - CW'(1);
                            else if (move_right && !move_left)
                                r_cursor <= (r_cursor == CW'(COLS-1)) ? '0 : r_cursor + CW'(1);
                            if (w_tick) begin
                                if (r_secs <= SW'(1)) begin
                                    r_secs    <= '0;
                                    r_timeout <= 1'b1;
                                    r_state   <= S_SWITCH;
                                end else begin
                                    r_secs <= r_secs - SW'(1);
                                end
                            end
                        end
                    end
                    S_DROP: begin
                        r_board[(w_rr*COLS+w_cc)*2 +: 2] <= w_me;
                        r_moves <= r_moves + MW'(1);
                        r_dir   <= '0;
                        r_state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (w_win) begin
                            r_winner <= w_me;
                            r_state  <= S_WIN;
                        end else if (r_dir == 2'd3) begin
                            r_state <= (r_moves == MW'(ROWS*COLS)) ? S_DRAW : S_SWITCH;
                        end else begin
                            r_dir <= r_dir + 2'd1;
                        end
                    end
                    S_SWITCH: begin
                        r_turn  <= ~r_turn;
                        r_secs  <= SW'(TURN_SECS);
                        r_tick  <= '0;
                        r_state <= S_PLAY;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign board        = r_board;
    assign cursor_col   = r_cursor;
    assign player_turn  = r_turn;
    assign state        = r_state;
    assign winner       = r_winner;
    assign seconds_left = r_secs;
    assign move_count   = r_moves;
    assign col_full     = r_col_full;
    assign timeout      = r_timeout;

endmodule

// File: tb/tb_connect_n_core.sv
// Directed bench for connect_n_core: drops, wins, full column, timer,
// cursor wrap, async reset and new_game.
module tb_connect_n_core;

    logic        clk;
    logic        reset;
    logic        move_left, move_right, move_made, new_game;
    logic [83:0] board;
    logic [2:0]  cursor_col;
    logic        player_turn;
    logic [2:0]  state;
    logic [1:0]  winner;
    logic [3:0]  seconds_left;
    logic [5:0]  move_count;
    logic        col_full, timeout;

    logic        rst2;
    logic        i2_l, i2_r, i2_m, i2_n;
    logic [83:0] b2_board;
    logic [2:0]  b2_cur;
    logic        b2_turn;
    logic [2:0]  b2_state;
    logic [1:0]  b2_win;
    logic [1:0]  b2_secs;
    logic [5:0]  b2_moves;
    logic        b2_full, b2_to;

    int n_chk = 0;
    int n_err = 0;

    logic [83:0] exp_board;
    int          exp_cur;
    int          h[7];

    connect_n_core dut (
        .clk(clk), .reset(reset),
        .move_left(move_left), .move_right(move_right),
        .move_made(move_made), .new_game(new_game),
        .board(board), .cursor_col(cursor_col),
        .player_turn(player_turn), .state(state),
        .winner(winner), .seconds_left(seconds_left),
        .move_count(move_count), .col_full(col_full),
        .timeout(timeout)
    );

    connect_n_core #(.TICK_DIV(4), .TURN_SECS(2)) dut2 (
        .clk(clk), .reset(rst2),
        .move_left(i2_l), .move_right(i2_r),
        .move_made(i2_m), .new_game(i2_n),
        .board(b2_board), .cursor_col(b2_cur),
        .player_turn(b2_turn), .state(b2_state),
        .winner(b2_win), .seconds_left(b2_secs),
        .move_count(b2_moves), .col_full(b2_full),
        .timeout(b2_to)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic set_cell(input int r, input int c, input logic [1:0] v);
        exp_board[(r*7+c)*2 +: 2] = v;
    endtask

    task automatic clear_model();
        exp_board = '0;
        exp_cur   = 0;
        for (int i = 0; i < 7; i++) h[i] = 0;
    endtask

    task automatic move_to(input int col);
        int n;
        n = (col - exp_cur + 7) % 7;
        for (int i = 0; i < n; i++) begin
            move_right = 1'b1;
            @(negedge clk);
            move_right = 1'b0;
            @(negedge clk);
        end
        exp_cur = col;
    endtask

    // Full turn: returns 7 cycles after move_made, back in PLAY.
    task automatic play(input int col, input int p, input logic also_right);
        move_to(col);
        move_made  = 1'b1;
        move_right = also_right;
        @(negedge clk);
        move_made  = 1'b0;
        move_right = 1'b0;
        repeat (6) @(negedge clk);
        set_cell(5 - h[col], col, (p == 0) ? 2'b01 : 2'b10);
        h[col]++;
    endtask

    task automatic pulse_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        clear_model();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_board"}, board, 84'd0);
        check({tag, "_cur"}, cursor_col, 3'd0);
        check({tag, "_turn"}, player_turn, 1'b0);
        check({tag, "_state"}, state, 3'd0);
        check({tag, "_winner"}, winner, 2'b00);
        check({tag, "_secs"}, seconds_left, 4'd10);
        check({tag, "_moves"}, move_count, 6'd0);
        check({tag, "_flags"}, {col_full, timeout}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; rst2 = 1'b1;
        move_left = 0; move_right = 0; move_made = 0; new_game = 0;
        i2_l = 0; i2_r = 0; i2_m = 0; i2_n = 0;
        clear_model();
        repeat (2) @(negedge clk);
        check_reset_vals("rst");

        // timer: TICK_DIV=4, TURN_SECS=2
        rst2 = 1'b0;
        repeat (7) @(negedge clk);
        check("t7_to", b2_to, 1'b0);
        check("t7_secs", b2_secs, 2'd1);
        @(negedge clk);
        check("t8_to", b2_to, 1'b1);
        check("t8_secs", b2_secs, 2'd0);
        check("t8_state", b2_state, 3'd3);
        @(negedge clk);
        check("t9_to", b2_to, 1'b0);
        check("t9_turn", b2_turn, 1'b1);
        check("t9_secs", b2_secs, 2'd2);
        check("t9_moves", b2_moves, 6'd0);

        reset = 1'b0;
        @(negedge clk);

        // cursor wrap and conflicting moves
        move_left = 1'b1;
        @(negedge clk);
        move_left = 1'b0;
        check("wrap_left", cursor_col, 3'd6);
        move_left = 1'b1; move_right = 1'b1;
        @(negedge clk);
        move_left = 1'b0; move_right = 1'b0;
        check("lr_same", cursor_col, 3'd6);
        move_right = 1'b1;
        @(negedge clk);
        move_right = 1'b0;
        check("wrap_right", cursor_col, 3'd0);

        // single drop timeline in column 3
        move_to(3);
        check("cur3", cursor_col, 3'd3);
        move_made = 1'b1;
        @(negedge clk);
        move_made = 1'b0;
        check("d_st_drop", state, 3'd1);
        check("d_board_t1", board, 84'd0);
        @(negedge clk);
        set_cell(5, 3, 2'b01);
        check("d_board_t2", board, exp_board);
        check("d_moves", move_count, 6'd1);
        check("d_st_check", state, 3'd2);
        repeat (4) @(negedge clk);
        check("d_st_switch", state, 3'd3);
        check("d_turn_t6", player_turn, 1'b0);
        @(negedge clk);
        check("d_turn_t7", player_turn, 1'b1);
        check("d_st_play", state, 3'd0);
        check("d_secs", seconds_left, 4'd10);

        // horizontal win for player 0
        pulse_new_game();
        check_reset_vals("ng");
        play(0, 0, 1'b0);
        play(6, 1, 1'b0);
        play(1, 0, 1'b1);
        check("prio_cur", cursor_col, 3'd1);
        play(6, 1, 1'b0);
        play(2, 0, 1'b0);
        play(6, 1, 1'b0);
        check("pre_win_board", board, exp_board);
        check("pre_win_turn", player_turn, 1'b0);
        move_to(3);
        move_made = 1'b1;
        @(negedge clk);
        move_made = 1'b0;
        check("w_drop", state, 3'd1);
        @(negedge clk);
        check("w_check", state, 3'd2);
        @(negedge clk);
        set_cell(5, 3, 2'b01);
        check("w_state", state, 3'd4);
        check("w_winner", winner, 2'b01);
        check("w_moves", move_count, 6'd7);
        check("w_board", board, exp_board);
        move_left = 1'b1; move_made = 1'b1;
        @(negedge clk);
        move_left = 1'b0; move_made = 1'b0;
        @(negedge clk);
        check("w_hold_st", state, 3'd4);
        check("w_hold_cur", cursor_col, 3'd3);
        check("w_hold_board", board, exp_board);
        check("w_hold_win", winner, 2'b01);
        pulse_new_game();
        check_reset_vals("ng_win");

        // fill column 2 then overflow
        for (int i = 0; i < 6; i++) play(2, i % 2, 1'b0);
        check("full_board", board, exp_board);
        check("full_moves", move_count, 6'd6);
        move_made = 1'b1;
        @(negedge clk);
        move_made = 1'b0;
        check("cf_pulse", col_full, 1'b1);
        check("cf_state", state, 3'd0);
        @(negedge clk);
        check("cf_clear", col_full, 1'b0);
        check("cf_state2", state, 3'd0);
        check("cf_board", board, exp_board);
        check("cf_turn", player_turn, 1'b0);
        check("cf_moves", move_count, 6'd6);

        // async reset in CHECK
        pulse_new_game();
        move_made = 1'b1;
        @(negedge clk);
        move_made = 1'b0;
        @(negedge clk);
        check("ar_in_check", state, 3'd2);
        #2 reset = 1'b1;
        #1;
        check_reset_vals("ar");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("ar_post");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
